// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush/bubble controller.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_HOLD = 2'b01,
        MEM_DONE = 2'b10
    } state_e;

    // Width of the hold-left counter: max(1, clog2(mem_wait_cycles)).
    function automatic int hold_w(input int mem_wait_cycles);
        return (mem_wait_cycles > 2) ? $clog2(mem_wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + ONE;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Decode-stage hazard responder: per-stage enable/flush/bubble decode, MEM freeze
// sequencing for multi-cycle accesses, and saturating event counters.
//
//  state    | meaning
//  RUN      | normal flow; flush/stall honoured, mem_req starts a freeze
//  MEM_HOLD | further freeze cycles while hold_left counts down
//  MEM_DONE | access completes this cycle; mem_req still high but ignored
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 3,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_req,
    input  logic             i_flush_req,
    input  logic             i_mem_req,
    input  logic             i_cnt_clr,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_bubble,
    output logic             o_mem_freeze,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_hold_cnt
);
    localparam int              F         = MEM_WAIT_CYCLES - 1;
    localparam int              HW        = hold_w(MEM_WAIT_CYCLES);
    localparam bit              MEM_EN    = (F >= 1);
    localparam bit              LONG_HOLD = (F >= 2);
    localparam logic [HW-1:0]   HOLD_INIT = HW'(LONG_HOLD ? F - 1 : 0);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

    state_e          r_state;
    logic [HW-1:0]   r_hold_left;

    logic w_mem_start;
    logic w_freeze;
    logic w_flush;
    logic w_stall;

    // Everything is gated by reset so the decode is idle while rst is held.
    assign w_mem_start = !i_rst && MEM_EN && (r_state == RUN) && i_mem_req;
    assign w_freeze    = w_mem_start || (!i_rst && (r_state == MEM_HOLD));
    assign w_flush     = !i_rst && !w_freeze && i_flush_req;
    assign w_stall     = !i_rst && !w_freeze && !i_flush_req && i_stall_req;

    assign o_pc_en         = !(w_freeze || w_stall);
    assign o_if_id_en      = !(w_freeze || w_stall);
    assign o_if_id_flush   = w_flush;
    assign o_id_ex_en      = !w_freeze;
    assign o_id_ex_flush   = w_flush || w_stall;
    assign o_ex_mem_en     = !w_freeze;
    assign o_mem_wb_bubble = w_freeze;
    assign o_mem_freeze    = w_freeze;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_hold_left <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_start) begin
                        r_hold_left <= HOLD_INIT;
                        r_state     <= LONG_HOLD ? MEM_HOLD : MEM_DONE;
                    end
                end
                MEM_HOLD: begin
                    if (r_hold_left == HOLD_ONE) begin
                        r_hold_left <= '0;
                        r_state     <= MEM_DONE;
                    end else begin
                        r_hold_left <= r_hold_left - HOLD_ONE;
                    end
                end
                MEM_DONE: r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (w_stall),
        .o_q   (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (w_flush),
        .o_q   (o_flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (w_freeze),
        .o_q   (o_hold_cnt)
    );

endmodule
